// File: rtl/adder_64b_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_64b_seq_ctrl
// Description : Two-pass sequencer that builds a 2*HALF_W-bit add out of one
//               external HALF_W-bit adder slice. The low half is added first,
//               its carry is held in a register, and the high half is added
//               on the next cycle using that carry.
//
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - operand handshake (in_a, in_b, in_cin)
//               add_a/add_b/add_cin -> external slice inputs
//               add_sum/add_cout  <- external slice outputs (same cycle)
//               out_valid/out_ready - result handshake (out_sum, out_cout)
//               busy              - high whenever the FSM is not idle
//               op_count          - wrapping count of handshaken results
//               out_ovf           - signed overflow (ADDER_SEQ_OVF_EN only)
//
// Options     : define ADDER_SEQ_OVF_EN to add the out_ovf port and logic.
//
// Revision    : 1.0 - initial release
// ============================================================================
module adder_64b_seq_ctrl #(
    parameter int HALF_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   in_a,
    input  logic [2*HALF_W-1:0]   in_b,
    input  logic                  in_cin,
    output logic [HALF_W-1:0]     add_a,
    output logic [HALF_W-1:0]     add_b,
    output logic                  add_cin,
    input  logic [HALF_W-1:0]     add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*HALF_W-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  busy,
`ifdef ADDER_SEQ_OVF_EN
    output logic                  out_ovf,
`endif
    output logic [CNT_W-1:0]      op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2*HALF_W-1:0] r_a;
    logic [2*HALF_W-1:0] r_b;
    logic                r_cin;
    logic [HALF_W-1:0]   r_sum_lo;
    logic                r_c_mid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and slice/handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                add_a       = r_a[HALF_W-1:0];
                add_b       = r_b[HALF_W-1:0];
                add_cin     = r_cin;
                w_state_nxt = S_HIGH;
            end
            S_HIGH: begin
                add_a       = r_a[2*HALF_W-1:HALF_W];
                add_b       = r_b[2*HALF_W-1:HALF_W];
                add_cin     = r_c_mid;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, partial sum, result and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_sum_lo  <= '0;
            r_c_mid   <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            op_count  <= '0;
`ifdef ADDER_SEQ_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_cin <= in_cin;
                    end
                end
                S_LOW: begin
                    r_sum_lo <= add_sum;
                    r_c_mid  <= add_cout;
                end
                S_HIGH: begin
                    out_sum   <= {add_sum, r_sum_lo};
                    out_cout  <= add_cout;
                    out_valid <= 1'b1;
`ifdef ADDER_SEQ_OVF_EN
                    // Overflow: like-signed operands producing an unlike-signed sum.
                    out_ovf   <= (r_a[2*HALF_W-1] == r_b[2*HALF_W-1]) &&
                                 (add_sum[HALF_W-1] != r_a[2*HALF_W-1]);
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_64b_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_64b_seq_ctrl
// Description : Self-checking bench for adder_64b_seq_ctrl. Provides a
//               behavioural model of the external HALF_W-bit adder slice and
//               checks results against a queue of expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_64b_seq_ctrl;

    localparam int HALF_W = 32;
    localparam int CNT_W  = 16;
    localparam int W      = 2 * HALF_W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic              in_cin;
    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic              add_cin;
    logic [HALF_W-1:0] add_sum;
    logic              add_cout;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_sum;
    logic              out_cout;
    logic              busy;
    logic [CNT_W-1:0]  op_count;
`ifdef ADDER_SEQ_OVF_EN
    logic              out_ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_cnt  = 0;
    logic [W:0] exp_q[$];

    adder_64b_seq_ctrl #(.HALF_W(HALF_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy),
`ifdef ADDER_SEQ_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .op_count  (op_count)
    );

    // External adder slice model
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{HALF_W{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare current result against the scoreboard head.
    task automatic pop_and_check(input string tag);
        logic [W:0] e;
        chk({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_sum"},  128'(out_sum),  128'(e[W-1:0]));
            chk({tag, "_cout"}, 128'(out_cout), 128'(e[W]));
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // One full operation from IDLE with immediate handshake; checks slice
    // drive in LOW/HIGH, 2-cycle latency and the op_count step.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [HALF_W:0] lo;
        logic [W:0]      full;
        lo   = {1'b0, a[HALF_W-1:0]} + {1'b0, b[HALF_W-1:0]} + {{HALF_W{1'b0}}, c};
        full = model(a, b, c);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
        exp_q.push_back(full);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_low_a"},     128'(add_a),   128'(a[HALF_W-1:0]));
        chk({tag, "_low_cin"},   128'(add_cin), 128'(c));
        chk({tag, "_low_ready"}, 128'(in_ready), 128'd0);
        @(negedge clk);
        chk({tag, "_high_a"},    128'(add_a),   128'(a[W-1:HALF_W]));
        chk({tag, "_high_b"},    128'(add_b),   128'(b[W-1:HALF_W]));
        chk({tag, "_high_cin"},  128'(add_cin), 128'(lo[HALF_W]));
        chk({tag, "_high_valid"}, 128'(out_valid), 128'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 128'(out_valid), 128'd1);
        chk({tag, "_done_add_a"}, 128'(add_a), 128'd0);
        pop_and_check(tag);
`ifdef ADDER_SEQ_OVF_EN
        chk({tag, "_ovf"}, 128'(out_ovf),
            128'((a[W-1] == b[W-1]) && (full[W-1] != a[W-1])));
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        chk({tag, "_valid_clr"}, 128'(out_valid), 128'd0);
        chk({tag, "_op_count"},  128'(op_count), 128'(exp_cnt));
        chk({tag, "_hold_sum"},  128'(out_sum),  128'(full[W-1:0]));
    endtask

    initial begin : main
        int nsent;
        int nrecv;
        int last_cyc;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_sum",   128'(out_sum),   128'd0);
        chk("rst_cout",  128'(out_cout),  128'd0);
        chk("rst_count", 128'(op_count),  128'd0);
        chk("rst_busy",  128'(busy),      128'd0);
        chk("rst_ready", 128'(in_ready),  128'd1);
        rst = 1'b0;
        @(negedge clk);

        // Carry propagates from low half into high half
        do_op("carry", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
        // Full-width wrap with carry out
        do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        chk("wrap_exact_sum", 128'(out_sum), 128'd0);
        chk("wrap_exact_cout", 128'(out_cout), 128'd1);

        // Backpressure with a pending request held on the input
        in_valid = 1'b1; in_a = 64'h1; in_b = 64'h2; in_cin = 1'b0;
        exp_q.push_back(model(64'h1, 64'h2, 1'b0));
        @(negedge clk);
        in_a = 64'd10; in_b = 64'd20;
        @(negedge clk);
        @(negedge clk);
        pop_and_check("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum_stable", 128'(out_sum),   128'd3);
            chk("bp_in_ready",   128'(in_ready),  128'd0);
            chk("bp_valid",      128'(out_valid), 128'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        chk("bp_after_hs_ready", 128'(in_ready),  128'd1);
        chk("bp_after_hs_valid", 128'(out_valid), 128'd0);
        chk("bp_count",          128'(op_count),  128'(exp_cnt));
        exp_q.push_back(model(64'd10, 64'd20, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_new_low_a", 128'(add_a), 128'd10);
        chk("bp_new_busy",  128'(busy),  128'd1);
        @(negedge clk);
        @(negedge clk);
        chk("bp_new_valid", 128'(out_valid), 128'd1);
        pop_and_check("bp_new");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;

        // Reset during HIGH aborts silently
        in_valid = 1'b1; in_a = 64'd5; in_b = 64'd7; in_cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy",  128'(busy),      128'd0);
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_sum",   128'(out_sum),   128'd0);
        chk("mid_rst_count", 128'(op_count),  128'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_result", 128'(out_valid), 128'd0);
        end
        exp_cnt = 0;

        // Back-to-back stream of 20 random operand pairs
        nsent = 0; nrecv = 0; last_cyc = 0;
        for (int t = 0; t < 200 && nrecv < 20; t++) begin
            if (out_valid) begin
                pop_and_check("stream");
                if (nrecv > 0) chk("stream_spacing", 128'(cyc - last_cyc), 128'd4);
                last_cyc = cyc;
                nrecv++;
            end
            if (in_ready) begin
                if (nsent < 20) begin
                    in_valid = 1'b1;
                    in_a = {$urandom, $urandom};
                    in_b = {$urandom, $urandom};
                    in_cin = 1'($urandom_range(0, 1));
                    exp_q.push_back(model(in_a, in_b, in_cin));
                    nsent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream_received", 128'(nrecv), 128'd20);
        chk("stream_count",    128'(op_count), 128'd20);
        exp_cnt = 20;

`ifdef ADDER_SEQ_OVF_EN
        do_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        chk("ovf_pos_set", 128'(out_ovf), 128'd1);
        do_op("ovf_neg", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("ovf_neg_set", 128'(out_ovf), 128'd1);
        chk("ovf_neg_cout", 128'(out_cout), 128'd1);
        do_op("ovf_none", 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        chk("ovf_none_clr", 128'(out_ovf), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
